// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings,
// counter-width helper and handshake levels.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake signal levels.
  localparam logic HS_ASSERT   = 1'b1;
  localparam logic HS_DEASSERT = 1'b0;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_step.sv
// One restoring-division iteration: shift {rem,q} left by one, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module seq_restoring_divider_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift-compare-subtract; the extra top bit of trial is the borrow/sign.
  always_comb begin
    shifted = {rem_in, q_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_out = trial[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider with valid/ready handshakes on both
// sides. One quotient bit is resolved per clock while BUSY.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData_A,
  input  logic [WIDTH-1:0] inData_B,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData_Q,
  output logic [WIDTH-1:0] outData_R,
  output logic             outDivZero
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic             dz_q,    dz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  seq_restoring_divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .q_in    (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_out   (step_quo)
  );

  // Ready is held low while reset is asserted, even though state is IDLE.
  assign inReady    = (rst_n && (state_q == IDLE)) ? HS_ASSERT : HS_DEASSERT;
  assign outValid   = (state_q == DONE) ? HS_ASSERT : HS_DEASSERT;
  assign outData_Q  = quo_q;
  assign outData_R  = rem_q;
  assign outDivZero = dz_q;

  // Next-state and datapath update; registers hold unless the state acts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (inValid && inReady) begin
          div_d = inData_B;
          cnt_d = CNT_W'(WIDTH);
          if (inData_B == '0) begin
            // Zero divisor short-circuits: saturated quotient, dividend kept.
            quo_d   = '1;
            rem_d   = inData_A;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = inData_A;
            rem_d   = '0;
            dz_d    = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (outReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (WIDTH=4).
module tb_seq_restoring_divider;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inData_A;
  logic [WIDTH-1:0] inData_B;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outData_Q;
  logic [WIDTH-1:0] outData_R;
  logic             outDivZero;

  int total = 0;
  int fails = 0;

  seq_restoring_divider #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inValid    (inValid),
    .inReady    (inReady),
    .inData_A   (inData_A),
    .inData_B   (inData_B),
    .outValid   (outValid),
    .outReady   (outReady),
    .outData_Q  (outData_Q),
    .outData_R  (outData_R),
    .outDivZero (outDivZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for inReady, then offers operands for exactly one edge.
  task automatic offer(input string tag, input int a, input int b);
    int g;
    g = 0;
    while (!inReady && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk({tag, "_ready"}, int'(inReady), 1);
    inData_A = WIDTH'(a);
    inData_B = WIDTH'(b);
    inValid  = 1'b1;
    @(posedge clk); #1;
    inValid  = 1'b0;
    inData_A = WIDTH'($urandom);
    inData_B = WIDTH'($urandom);
  endtask

  // Full operation with outReady high; latency counts the accepting edge as 1.
  task automatic do_op(input string tag, input int a, input int b,
                       input int eq, input int er, input int edz, input int elat);
    int lat;
    outReady = 1'b1;
    offer(tag, a, b);
    lat = 1;
    while (!outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, int'(outData_Q), eq);
    chk({tag, "_r"}, int'(outData_R), er);
    chk({tag, "_dz"}, int'(outDivZero), edz);
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, int'(outValid), 0);
    chk({tag, "_rdy_back"}, int'(inReady), 1);
  endtask

  initial begin
    int seen;
    int a, b, g;
    inValid  = 1'b0;
    outReady = 1'b1;
    inData_A = '0;
    inData_B = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_inReady", int'(inReady), 0);
    chk("rst_outValid", int'(outValid), 0);
    chk("rst_q", int'(outData_Q), 0);
    chk("rst_r", int'(outData_R), 0);
    chk("rst_dz", int'(outDivZero), 0);
    rst_n = 1'b1;
    #1;
    chk("idle_inReady", int'(inReady), 1);

    // Main cases and edge values
    do_op("d13_3", 13, 3, 4, 1, 0, WIDTH + 1);
    do_op("d9_0", 9, 0, 15, 9, 1, 1);
    do_op("d15_1", 15, 1, 15, 0, 0, WIDTH + 1);
    do_op("d2_7", 2, 7, 0, 2, 0, WIDTH + 1);
    do_op("d0_5", 0, 5, 0, 0, 0, WIDTH + 1);
    do_op("d15_15", 15, 15, 1, 0, 0, WIDTH + 1);

    // Backpressure: result held for 3 cycles while other operands are offered
    outReady = 1'b0;
    offer("bp", 14, 4);
    g = 1;
    while (!outValid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("bp_lat", g, WIDTH + 1);
    inData_A = 4'd1;
    inData_B = 4'd1;
    inValid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_vld%0d", i), int'(outValid), 1);
      chk($sformatf("bp_q%0d", i), int'(outData_Q), 3);
      chk($sformatf("bp_r%0d", i), int'(outData_R), 2);
      chk($sformatf("bp_inrdy%0d", i), int'(inReady), 0);
      @(posedge clk); #1;
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_vld_drop", int'(outValid), 0);
    chk("bp_rdy_back", int'(inReady), 1);
    do_op("bp_after", 11, 2, 5, 1, 0, WIDTH + 1);

    // Reset two cycles into BUSY
    offer("rst_mid", 13, 3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_vld", int'(outValid), 0);
    chk("rstmid_q", int'(outData_Q), 0);
    chk("rstmid_r", int'(outData_R), 0);
    chk("rstmid_dz", int'(outDivZero), 0);
    chk("rstmid_inrdy", int'(inReady), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (outValid) seen = 1;
    end
    chk("rstmid_no_pulse", seen, 0);
    do_op("d6_2", 6, 2, 3, 0, 0, WIDTH + 1);

    // Multiplier round-trip: (x*y)/y == x, remainder 0
    for (int x = 0; x < 4; x++) begin
      for (int y = 1; y < 4; y++) begin
        do_op($sformatf("rt%0dx%0d", x, y), x * y, y, x, 0, 0, WIDTH + 1);
      end
    end

    // Random sweep with identity checks
    for (int i = 0; i < 12; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(1, 15));
      do_op($sformatf("rnd%0d", i), a, b, a / b, a % b, 0, WIDTH + 1);
      chk($sformatf("rnd%0d_ident", i), int'(outData_Q) * b + int'(outData_R), a);
      chk($sformatf("rnd%0d_rlt", i), int'(int'(outData_R) < b), 1);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative restoring divider that computes the inverse operation of the team's combinational vedic multipliers: dividend / divisor -> quotient and remainder.
- Produces one quotient bit per clock. It sits beside the multiplier array in the matrix datapath for normalisation and inverse-scaling.
- Operands are accepted and results delivered over valid/ready handshakes, so it can sit between pipeline stages with backpressure.

Parameters:
- WIDTH, 4, bit width of dividend, divisor, quotient and remainder. Must be 2 or more.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter. Derived; do not override.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- inValid  input  1  operands on inData_A/inData_B are valid.
- inReady  output  1  block can accept operands.
- inData_A  input  WIDTH  dividend, unsigned.
- inData_B  input  WIDTH  divisor, unsigned.
- outValid  output  1  result outputs are valid.
- outReady  input  1  downstream accepts the result.
- outData_Q  output  WIDTH  quotient.
- outData_R  output  WIDTH  remainder.
- outDivZero  output  1  result came from a zero divisor.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; inReady=0 while reset is asserted, then 1 in IDLE.
  - outValid=0, outData_Q=0, outData_R=0, outDivZero=0, counter=0.
- FSM states: IDLE, BUSY, DONE.
  - inReady = (state==IDLE).
  - outValid = (state==DONE).
- IDLE: when inValid&&inReady at an edge:
  - Latch the dividend into the quotient/shift register and the divisor into the divisor register.
  - Clear the partial remainder. Set counter=WIDTH.
  - If inData_B==0, go to DONE with Q=all ones, R=dividend, outDivZero=1.
  - Otherwise go to BUSY with outDivZero=0.
- BUSY: one restoring step per edge.
  - Form {R,Q} shifted left by 1.
  - Compute trial = R_shifted - divisor in WIDTH+1 bits.
  - If trial is non-negative: R=trial[WIDTH-1:0] and Q LSB=1.
  - Otherwise keep R_shifted and set Q LSB=0.
  - Decrement counter. On the edge where counter goes 1->0, go to DONE.
- DONE: outputs are held stable while outValid=1 and outReady=0.
  - When outValid&&outReady at an edge, go to IDLE.
  - Outputs keep their last values after leaving DONE; they are don't-care when outValid=0.
- Latency:
  - Nonzero divisor: outValid rises WIDTH+1 edges after the accepting edge (1 load edge folded into the first BUSY edge is not allowed; load and steps are separate).
  - Zero divisor: outValid rises 1 edge after acceptance.
- Throughput: at most one operation per WIDTH+2 cycles. No operand is accepted in BUSY or DONE; inReady=0 there.
- Arithmetic rules:
  - Unsigned only.
  - Remainder is always < divisor.
  - Q*divisor + R == dividend for every nonzero divisor.
  - The subtractor is WIDTH+1 bits wide so that the shifted remainder cannot overflow.
- Simultaneous events:
  - inValid asserted during BUSY/DONE is ignored. Upstream must hold its data, per the handshake rules.
  - outReady is ignored outside DONE.
- Reset mid-operation: an immediate return to IDLE; the partial result is discarded and no outValid pulse is produced.
- inData_A/inData_B are sampled only on the accepting edge; changes at any other time have no effect.

Decomposition:
- Shared package/header:
  - FSM state encodings as localparams: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Derived CNT_W function.
  - Common handshake constants.
- Sub-module divider_step: combinational, parameterised by WIDTH.
  - Inputs: rem_in, q_in, divisor.
  - Outputs: rem_out, q_out.
  - Implements one shift-compare-subtract step.
- The top level holds the FSM, counter, registers and handshake logic.

Test Plan:
- WIDTH=4, A=13, B=3, outReady=1 -> outValid high exactly 5 edges after acceptance, Q=4, R=1, outDivZero=0, then inReady=1 on the next cycle.
- A=9, B=0 -> outValid 1 edge after acceptance, Q=15, R=9, outDivZero=1.
- Edge values:
  - A=15, B=1 -> Q=15, R=0.
  - A=2, B=7 -> Q=0, R=2.
  - A=0, B=5 -> Q=0, R=0.
- Backpressure: A=14, B=4, outReady held low 3 cycles in DONE -> Q=3 and R=2 stable, outValid held, inReady=0; operands offered meanwhile are not accepted.
- Reset mid-operation: assert rst_n=0 two cycles into BUSY -> all outputs 0 immediately; after release a new A=6, B=2 completes with Q=3, R=0.
- Multiplier round-trip: for all 2-bit x and nonzero y, feed the 4-bit product x*y as A and y as B -> Q=x, R=0 for every pair. Also run a random sweep checking Q*B+R==A and R<B.
